// File: rtl/deinterleaver_pkg.sv
// Shared widths and state encoding for the deinterleaver sequencer.
package deinterleaver_pkg;

    localparam logic [1:0] S_LOAD = 2'd0;
    localparam logic [1:0] S_IDLE = 2'd1;
    localparam logic [1:0] S_RUN  = 2'd2;

    // Width of one sweepstart chunk (and of a group index).
    function automatic int calc_cw(input int p, input int z);
        return $clog2(p / z);
    endfunction

    // Width of one weight index.
    function automatic int calc_w(input int p, input int fo);
        return $clog2(p * fo);
    endfunction

    // Width of the sweep counter; at least one bit even when fo = 1.
    function automatic int calc_sw(input int fo);
        return (fo > 1) ? $clog2(fo) : 1;
    endfunction

    // Total width of the sweepstart register.
    function automatic int calc_ssw(input int p, input int z, input int fo);
        return calc_cw(p, z) * fo * z;
    endfunction

    // Width of the chunk load counter.
    function automatic int calc_cntw(input int fo, input int z);
        return (fo * z > 1) ? $clog2(fo * z) : 1;
    endfunction

endpackage

// File: rtl/deinterleaver_lane.sv
// One lane of the inverse mapping: group, sweep and sweepstart chunk -> weight index.
module deinterleaver_lane
    import deinterleaver_pkg::*;
#(
    parameter int p    = 32,
    parameter int z    = 8,
    parameter int fo   = 2,
    parameter int lane = 0
) (
    input  logic [calc_cw(p, z)-1:0]  group_i,
    input  logic [calc_cw(p, z)-1:0]  chunk_i,
    input  logic [calc_sw(fo)-1:0]    sweep_i,
    output logic [calc_w(p, fo)-1:0]  w_o
);

    localparam int CW = calc_cw(p, z);
    localparam int W  = calc_w(p, fo);

    logic [CW-1:0] gi_s;

    // The CW-bit subtraction wraps naturally, giving (k - chunk) mod p/z.
    always_comb begin
        gi_s = group_i - chunk_i;
        w_o  = (W'(sweep_i) * W'(p)) + (W'(gi_s) * W'(z)) + W'(lane);
    end

endmodule

// File: rtl/deinterleaver_seq.sv
// Sequencer: serially loads sweepstart, then emits fo weight-index beats per group.
module deinterleaver_seq
    import deinterleaver_pkg::*;
#(
    parameter int fo = 2,
    parameter int fi = 4,
    parameter int p  = 32,
    parameter int n  = 8,
    parameter int z  = 8
) (
    input  logic                          clk,
    input  logic                          reset,
    input  logic                          ss_load_valid,
    input  logic [calc_cw(p, z)-1:0]      ss_load_chunk,
    output logic                          ss_loaded,
    input  logic                          in_valid,
    output logic                          in_ready,
    input  logic [calc_cw(p, z)-1:0]      in_group,
    output logic                          out_valid,
    input  logic                          out_ready,
    output logic [calc_sw(fo)-1:0]        out_sweep,
    output logic                          out_last,
    output logic [calc_w(p, fo)*z-1:0]    out_wt_package
);

    localparam int CW   = calc_cw(p, z);
    localparam int W    = calc_w(p, fo);
    localparam int SW   = calc_sw(fo);
    localparam int SS_W = calc_ssw(p, z, fo);
    localparam int CNTW = calc_cntw(fo, z);
    localparam int NCH  = fo * z;

    localparam bit PARAMS_OK = (fi > 0) && (n > 0) && (fo > 0) && ((fo & (fo - 1)) == 0)
                               && (p % z == 0) && (p / z >= 2)
                               && (((p / z) & ((p / z) - 1)) == 0);

    if (!PARAMS_OK) begin : g_bad_params
        $error("deinterleaver_seq: illegal parameter set");
    end

    logic [1:0]      state_q, state_d;
    logic [CNTW-1:0] cnt_q, cnt_d;
    logic [SS_W-1:0] ss_q, ss_d;
    logic [CW-1:0]   group_q, group_d;
    logic [SW-1:0]   sweep_q, sweep_d;
    logic            run_s;
    logic            last_s;
    logic            accept_s;
    logic [W*z-1:0]  pkg_s;

    assign run_s    = (state_q == S_RUN);
    assign last_s   = run_s && (sweep_q == SW'(fo - 1));
    assign in_ready = (state_q == S_IDLE) || (last_s && out_ready);
    assign accept_s = in_valid && in_ready;

    assign ss_loaded      = (state_q != S_LOAD);
    assign out_valid      = run_s;
    assign out_last       = last_s;
    assign out_sweep      = run_s ? sweep_q : '0;
    assign out_wt_package = run_s ? pkg_s : '0;

    for (genvar j = 0; j < z; j++) begin : g_lane
        logic [CW-1:0] chunk_s;

        // Pick this lane's sweepstart chunk for the current sweep.
        always_comb begin
            chunk_s = '0;
            for (int s = 0; s < fo; s++) begin
                chunk_s = chunk_s | ((int'(sweep_q) == s) ? ss_q[(s*z+j)*CW +: CW] : '0);
            end
        end

        deinterleaver_lane #(
            .p    (p),
            .z    (z),
            .fo   (fo),
            .lane (j)
        ) u_lane (
            .group_i (group_q),
            .chunk_i (chunk_s),
            .sweep_i (sweep_q),
            .w_o     (pkg_s[j*W +: W])
        );
    end

    // Next-state logic: chunk loading, request acceptance and sweep stepping.
    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        ss_d    = ss_q;
        group_d = group_q;
        sweep_d = sweep_q;
        case (state_q)
            S_LOAD: begin
                if (ss_load_valid) begin
                    for (int i = 0; i < NCH; i++) begin
                        if (cnt_q == CNTW'(i)) begin
                            ss_d[i*CW +: CW] = ss_load_chunk;
                        end else begin
                            ss_d[i*CW +: CW] = ss_q[i*CW +: CW];
                        end
                    end
                    cnt_d = cnt_q + CNTW'(1);
                    if (cnt_q == CNTW'(NCH - 1)) begin
                        state_d = S_IDLE;
                    end else begin
                        state_d = S_LOAD;
                    end
                end else begin
                    state_d = S_LOAD;
                end
            end
            S_IDLE: begin
                if (accept_s) begin
                    group_d = in_group;
                    sweep_d = '0;
                    state_d = S_RUN;
                end else begin
                    state_d = S_IDLE;
                end
            end
            S_RUN: begin
                if (out_ready) begin
                    if (last_s) begin
                        // A request taken on the last beat restarts without a bubble.
                        if (accept_s) begin
                            group_d = in_group;
                            sweep_d = '0;
                            state_d = S_RUN;
                        end else begin
                            state_d = S_IDLE;
                        end
                    end else begin
                        sweep_d = sweep_q + SW'(1);
                    end
                end else begin
                    state_d = S_RUN;
                end
            end
            default: begin
                state_d = S_LOAD;
            end
        endcase
    end

    // State registers with synchronous reset; sweepstart must be reloaded after reset.
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q <= S_LOAD;
            cnt_q   <= '0;
            ss_q    <= '0;
            group_q <= '0;
            sweep_q <= '0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            ss_q    <= ss_d;
            group_q <= group_d;
            sweep_q <= sweep_d;
        end
    end

endmodule

// File: tb/tb_deinterleaver_seq.sv
// Randomized self-checking bench for deinterleaver_seq against a search-based inverse model.
module tb_deinterleaver_seq;

    localparam int FO   = 2;
    localparam int FI   = 4;
    localparam int P    = 32;
    localparam int N    = 8;
    localparam int Z    = 8;
    localparam int G    = P / Z;
    localparam int CW   = $clog2(G);
    localparam int W    = $clog2(P * FO);
    localparam int SW   = (FO > 1) ? $clog2(FO) : 1;
    localparam int SS_W = CW * FO * Z;
    localparam int NCH  = FO * Z;

    logic              clk = 1'b0;
    logic              reset = 1'b1;
    logic              ss_load_valid = 1'b0;
    logic [CW-1:0]     ss_load_chunk = '0;
    logic              ss_loaded;
    logic              in_valid = 1'b0;
    logic              in_ready;
    logic [CW-1:0]     in_group = '0;
    logic              out_valid;
    logic              out_ready = 1'b0;
    logic [SW-1:0]     out_sweep;
    logic              out_last;
    logic [W*Z-1:0]    out_wt_package;

    int passed = 0;
    int total  = 0;

    // Reference model state
    bit              m_loaded;
    int              m_cnt;
    bit              m_busy;
    int              m_group;
    int              m_sweep;
    logic [SS_W-1:0] m_ss;
    int              hits [P*FO];
    logic [W*Z-1:0]  last_pkg;

    always #5 clk = ~clk;

    deinterleaver_seq #(
        .fo (FO), .fi (FI), .p (P), .n (N), .z (Z)
    ) dut (
        .clk            (clk),
        .reset          (reset),
        .ss_load_valid  (ss_load_valid),
        .ss_load_chunk  (ss_load_chunk),
        .ss_loaded      (ss_loaded),
        .in_valid       (in_valid),
        .in_ready       (in_ready),
        .in_group       (in_group),
        .out_valid      (out_valid),
        .out_ready      (out_ready),
        .out_sweep      (out_sweep),
        .out_last       (out_last),
        .out_wt_package (out_wt_package)
    );

    task automatic check_val(input string tag, input longint obs, input longint exp);
        total++;
        if (obs == exp) passed++;
        else $display("FAIL %s: got %0d, expected %0d", tag, obs, exp);
    endtask

    function automatic int chunk_of(input logic [SS_W-1:0] ss, input int idx);
        return int'((ss >> (idx * CW)) & SS_W'(G - 1));
    endfunction

    // Forward interleaver: cycle c, lane j -> memory address.
    function automatic int fwd(input logic [SS_W-1:0] ss, input int c, input int j);
        int s;
        int g;
        s = c / G;
        g = c % G;
        return ((g + chunk_of(ss, s * Z + j)) % G) * Z + j;
    endfunction

    // Invert by search: the weight of sweep s on lane j that lands on neuron k*Z+j.
    function automatic int expect_w(input logic [SS_W-1:0] ss, input int k, input int s, input int j);
        int w;
        for (int gi = 0; gi < G; gi++) begin
            w = s * P + gi * Z + j;
            if (fwd(ss, w / Z, j) == k * Z + j) return w;
        end
        return -1;
    endfunction

    // One clock: drive, sample at negedge, compare with model, advance model.
    task automatic cycle(input bit ld_v, input int ld_c, input bit iv, input int ig, input bit ordy);
        bit exp_rdy;
        int w;
        ss_load_valid = ld_v;
        ss_load_chunk = CW'(ld_c);
        in_valid      = iv;
        in_group      = CW'(ig);
        out_ready     = ordy;
        @(negedge clk);
        exp_rdy = m_loaded && (!m_busy || ((m_sweep == FO - 1) && ordy));
        check_val("ss_loaded", longint'(ss_loaded), longint'(m_loaded));
        check_val("in_ready", longint'(in_ready), longint'(exp_rdy));
        check_val("out_valid", longint'(out_valid), longint'(m_busy));
        if (m_busy) begin
            check_val("out_sweep", longint'(out_sweep), longint'(m_sweep));
            check_val("out_last", longint'(out_last), longint'(m_sweep == FO - 1));
            for (int j = 0; j < Z; j++) begin
                w = int'(out_wt_package[j*W +: W]);
                check_val($sformatf("lane%0d_k%0d_s%0d", j, m_group, m_sweep), longint'(w),
                          longint'(expect_w(m_ss, m_group, m_sweep, j)));
                if (ordy) hits[w]++;
            end
        end else begin
            check_val("pkg_idle_zero", longint'(out_wt_package), 64'd0);
            check_val("last_idle_zero", longint'(out_last), 64'd0);
        end
        last_pkg = out_wt_package;
        if (!m_loaded && ld_v) begin
            m_cnt++;
            if (m_cnt == NCH) m_loaded = 1'b1;
        end
        if (m_busy && ordy) begin
            if (m_sweep == FO - 1) m_busy = 1'b0;
            else m_sweep++;
        end
        if (iv && exp_rdy) begin
            m_busy  = 1'b1;
            m_group = ig;
            m_sweep = 0;
        end
        @(posedge clk);
        #1;
    endtask

    task automatic reset_dut();
        reset         = 1'b1;
        ss_load_valid = 1'b0;
        in_valid      = 1'b0;
        out_ready     = 1'b0;
        @(posedge clk);
        #1;
        reset    = 1'b0;
        m_loaded = 1'b0;
        m_cnt    = 0;
        m_busy   = 1'b0;
        check_val("rst_out_valid", longint'(out_valid), 64'd0);
        check_val("rst_ss_loaded", longint'(ss_loaded), 64'd0);
        check_val("rst_in_ready", longint'(in_ready), 64'd0);
        check_val("rst_pkg", longint'(out_wt_package), 64'd0);
    endtask

    task automatic load_ss(input logic [SS_W-1:0] v);
        m_ss = v;
        for (int c = 0; c < NCH; c++) begin
            while ($urandom_range(0, 2) == 0) cycle(1'b0, 0, 1'b0, 0, 1'b1);
            cycle(1'b1, chunk_of(v, c), 1'b0, 0, 1'b1);
        end
    endtask

    task automatic random_traffic(input int cycles);
        for (int t = 0; t < cycles; t++) begin
            cycle($urandom_range(0, 1) == 1, int'($urandom_range(0, G - 1)),
                  $urandom_range(0, 2) != 0, int'($urandom_range(0, G - 1)),
                  $urandom_range(0, 3) != 0);
        end
    endtask

    initial begin
        logic [W*Z-1:0] held;
        reset_dut();
        cycle(1'b0, 0, 1'b1, 0, 1'b1);   // request ignored while unloaded
        load_ss(32'h8772D82D);
        check_val("loaded_after_16", longint'(ss_loaded), 64'd1);

        // Directed group 0: known lane values
        cycle(1'b0, 0, 1'b1, 0, 1'b1);
        cycle(1'b0, 0, 1'b0, 0, 1'b1);
        check_val("g0s0_lane0", longint'(last_pkg[0*W +: W]), 64'd24);
        check_val("g0s0_lane1", longint'(last_pkg[1*W +: W]), 64'd9);
        check_val("g0s0_lane2", longint'(last_pkg[2*W +: W]), 64'd18);
        check_val("g0s0_lane3", longint'(last_pkg[3*W +: W]), 64'd3);
        cycle(1'b0, 0, 1'b0, 0, 1'b1);
        check_val("g0s1_lane0", longint'(last_pkg[0*W +: W]), 64'd48);
        cycle(1'b0, 0, 1'b0, 0, 1'b1);

        // Back-to-back sweep over every group; every index must appear once
        for (int i = 0; i < P * FO; i++) hits[i] = 0;
        for (int t = 0; t <= G * FO; t++) begin
            cycle(1'b0, 0, (t % FO == 0) && (t / FO < G), t / FO, 1'b1);
        end
        for (int i = 0; i < P * FO; i++) check_val($sformatf("cover_w%0d", i), longint'(hits[i]), 64'd1);

        // Backpressure: outputs hold for three stalled cycles
        cycle(1'b0, 0, 1'b1, 2, 1'b1);
        cycle(1'b0, 0, 1'b0, 0, 1'b0);
        held = last_pkg;
        cycle(1'b0, 0, 1'b0, 0, 1'b0);
        check_val("stall_hold1", longint'(last_pkg), longint'(held));
        cycle(1'b0, 0, 1'b0, 0, 1'b0);
        check_val("stall_hold2", longint'(last_pkg), longint'(held));
        cycle(1'b0, 0, 1'b0, 0, 1'b1);
        cycle(1'b0, 0, 1'b0, 0, 1'b1);

        random_traffic(300);

        // Mid-burst reset during sweep 0
        cycle(1'b0, 0, 1'b1, 3, 1'b1);
        cycle(1'b0, 0, 1'b0, 0, 1'b0);
        reset_dut();
        repeat (4) cycle(1'b0, 0, 1'b1, 1, 1'b1);
        load_ss(SS_W'($urandom));
        random_traffic(300);

        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

endmodule
